// File: rtl/mnist_test_sequencer.sv
// mnist_test_sequencer: on-chip self-test controller for the MNIST classifier.
// Walks the test-image ROM image by image, streams each image's bytes into the
// classifier, samples the predicted digit a fixed latency after the last byte
// and tallies matches against the expected label (image index mod 10).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           begin a run (honoured only in IDLE or DONE)
//   abort_i           return to IDLE next cycle, counters kept
//   stop_on_fail_i    end the run on the first mismatch
//   pause_i           hold between images while high
//   rom_addr_o        {image_index, byte_index} into the test-image ROM
//   rom_data_i        synchronous ROM data, one cycle after rom_addr_o
//   pix_data_o        ROM byte forwarded to the classifier (zero when invalid)
//   pix_valid_o       pix_data_o holds a requested byte
//   res_index_i       classifier predicted digit
//   image_index_o     image under test
//   expected_o        label of image_index_o
//   pass_count_o      matching images this run
//   fail_count_o      mismatching images this run
//   first_fail_o      index of the first mismatching image
//   busy_o, done_o    run in progress / run complete
//   failed_o          at least one mismatch this run
module mnist_test_sequencer #(
  parameter int unsigned IMAGE_COUNT     = 480,
  parameter int unsigned BYTES_PER_IMAGE = 32,
  parameter int unsigned RESULT_DELAY    = 4,
  localparam int unsigned IW = $clog2(IMAGE_COUNT),
  localparam int unsigned BW = $clog2(BYTES_PER_IMAGE),
  localparam int unsigned CW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          stop_on_fail_i,
  input  logic          pause_i,
  output logic [IW+BW-1:0] rom_addr_o,
  input  logic [7:0]    rom_data_i,
  output logic [7:0]    pix_data_o,
  output logic          pix_valid_o,
  input  logic [3:0]    res_index_i,
  output logic [IW-1:0] image_index_o,
  output logic [3:0]    expected_o,
  output logic [CW-1:0] pass_count_o,
  output logic [CW-1:0] fail_count_o,
  output logic [IW-1:0] first_fail_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          failed_o
);

  localparam int unsigned WW = $clog2(RESULT_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [IW-1:0] image_q, image_d;
  logic [IW-1:0] first_fail_q, first_fail_d;
  logic [3:0]    expected_q, expected_d;
  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          pix_valid_q, pix_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          failed_q, failed_d;

  logic last_byte;
  logic last_image;
  logic match;

  assign last_byte  = (byte_q == BW'(BYTES_PER_IMAGE - 1));
  assign last_image = (image_q == IW'(IMAGE_COUNT - 1));
  // Labels are 0..9, so predictions 10..15 can never match.
  assign match      = (res_index_i == expected_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (start_i) state_d = S_FETCH;
        S_FETCH:        if (last_byte) state_d = S_WAIT;
        S_WAIT:         if (wait_q == WW'(1)) state_d = S_CHECK;
        S_CHECK: begin
          if (!match && stop_on_fail_i) state_d = S_DONE;
          else if (last_image)          state_d = S_DONE;
          else                          state_d = S_NEXT;
        end
        S_NEXT:         if (!pause_i) state_d = S_FETCH;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    byte_d       = byte_q;
    image_d      = image_q;
    first_fail_d = first_fail_q;
    expected_d   = expected_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    wait_d       = wait_q;
    // A byte whose address went out in the abort cycle is dropped.
    pix_valid_d  = (state_q == S_FETCH) && !abort_i;

    if (!abort_i) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            byte_d       = '0;
            image_d      = '0;
            first_fail_d = '0;
            expected_d   = '0;
            pass_d       = '0;
            fail_d       = '0;
          end
        end
        S_FETCH: begin
          // Byte index stays on the last byte so the address is quiet in WAIT.
          if (last_byte) wait_d = WW'(RESULT_DELAY);
          else           byte_d = byte_q + BW'(1);
        end
        S_WAIT: wait_d = wait_q - WW'(1);
        S_CHECK: begin
          if (match) begin
            if (pass_q != CW'(IMAGE_COUNT)) pass_d = pass_q + CW'(1);
          end else begin
            if (fail_q != CW'(IMAGE_COUNT)) fail_d = fail_q + CW'(1);
            if (fail_q == '0) first_fail_d = image_q;
          end
        end
        S_NEXT: begin
          // Advance only when leaving, so a held pause advances exactly once.
          if (!pause_i) begin
            image_d    = image_q + IW'(1);
            expected_d = (expected_q == 4'd9) ? 4'd0 : expected_q + 4'd1;
            byte_d     = '0;
          end
        end
        default: ;
      endcase
    end

    busy_d   = (state_d == S_FETCH) || (state_d == S_WAIT) ||
               (state_d == S_CHECK) || (state_d == S_NEXT);
    done_d   = (state_d == S_DONE);
    failed_d = (fail_d != '0);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q       <= '0;
      image_q      <= '0;
      first_fail_q <= '0;
      expected_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      wait_q       <= '0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      byte_q       <= byte_d;
      image_q      <= image_d;
      first_fail_q <= first_fail_d;
      expected_q   <= expected_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      wait_q       <= wait_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      failed_q     <= failed_d;
    end
  end

  assign rom_addr_o    = {image_q, byte_q};
  assign pix_data_o    = pix_valid_q ? rom_data_i : 8'h00;
  assign pix_valid_o   = pix_valid_q;
  assign image_index_o = image_q;
  assign expected_o    = expected_q;
  assign pass_count_o  = pass_q;
  assign fail_count_o  = fail_q;
  assign first_fail_o  = first_fail_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign failed_o      = failed_q;

endmodule

// File: tb/tb_mnist_test_sequencer.sv
// Testbench for mnist_test_sequencer: synchronous ROM model, a classifier model
// with a fixed result latency and an optional wrong answer on one image, a
// table of full runs, and directed sequences for reset, pause and abort.
module tb_mnist_test_sequencer;

  localparam int N  = 20;
  localparam int B  = 32;
  localparam int R  = 4;
  localparam int IW = 5;
  localparam int BW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, abort, stop_on_fail, pause;
  logic [IW+BW-1:0] rom_addr;
  logic [7:0]      rom_data;
  logic [7:0]      pix_data;
  logic            pix_valid;
  logic [3:0]      res_index;
  logic [IW-1:0]   image_index;
  logic [3:0]      expected;
  logic [IW:0]     pass_count, fail_count;
  logic [IW-1:0]   first_fail;
  logic            busy, done, failed;

  int checks   = 0;
  int failures = 0;

  // classifier model state
  int pix_total, pix_err, dly, img_pending;
  int wrong_img, wrong_val;

  typedef struct {
    int wrong_img;
    int wrong_val;
    int stop;
    int exp_pass;
    int exp_fail;
    int exp_first;
    int exp_img;
    int exp_label;
    int exp_edges;  // clock edges from the one sampling start to done rising
    int exp_pix;
  } vec_t;

  vec_t tv[6];

  mnist_test_sequencer #(
    .IMAGE_COUNT(N), .BYTES_PER_IMAGE(B), .RESULT_DELAY(R)
  ) dut (
    .clk(clk), .rst(rst),
    .start_i(start), .abort_i(abort), .stop_on_fail_i(stop_on_fail), .pause_i(pause),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .pix_data_o(pix_data), .pix_valid_o(pix_valid),
    .res_index_i(res_index),
    .image_index_o(image_index), .expected_o(expected),
    .pass_count_o(pass_count), .fail_count_o(fail_count), .first_fail_o(first_fail),
    .busy_o(busy), .done_o(done), .failed_o(failed)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int a);
    return 8'((a * 37 + 11) ^ (a >> 3));
  endfunction

  function automatic logic [3:0] label_f(input int img);
    if (img == wrong_img) return 4'(wrong_val);
    return 4'(img % 10);
  endfunction

  // ROM and classifier: result appears R cycles after the last byte of an image,
  // and reads 15 from the first byte of each image until then.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_data    <= 8'h00;
      pix_total   <= 0;
      pix_err     <= 0;
      dly         <= 0;
      img_pending <= 0;
      res_index   <= 4'hF;
    end else begin
      rom_data <= rom_f(int'(rom_addr));
      if (start && !busy) begin
        pix_total <= 0;
        pix_err   <= 0;
        dly       <= 0;
        res_index <= 4'hF;
      end else begin
        if (dly == 1) res_index <= label_f(img_pending);
        if (dly > 0) dly <= dly - 1;
        if (pix_valid) begin
          if (pix_data != rom_f(pix_total)) pix_err <= pix_err + 1;
          pix_total <= pix_total + 1;
          if (pix_total % B == 0) res_index <= 4'hF;
          if (pix_total % B == B - 1) begin
            dly         <= R - 1;
            img_pending <= pix_total / B;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int cyc;
    int exp_err;
    wrong_img    = tv[i].wrong_img;
    wrong_val    = tv[i].wrong_val;
    stop_on_fail = (tv[i].stop != 0);
    pulse_start();
    cyc = 0;
    chk($sformatf("v%0d_busy_c0", i), int'(busy), 1);
    chk($sformatf("v%0d_pass_c0", i), int'(pass_count), 0);
    chk($sformatf("v%0d_fail_c0", i), int'(fail_count), 0);
    chk($sformatf("v%0d_failed_c0", i), int'(failed), 0);
    chk($sformatf("v%0d_addr_c0", i), int'(rom_addr), 0);
    chk($sformatf("v%0d_pv_c0", i), int'(pix_valid), 0);
    @(negedge clk);
    cyc = 1;
    chk($sformatf("v%0d_pv_c1", i), int'(pix_valid), 1);
    chk($sformatf("v%0d_addr_c1", i), int'(rom_addr), 1);
    exp_err = 0;
    while (!done && cyc < 2000) begin
      if (int'(expected) != int'(image_index) % 10) exp_err++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_done_edges", i), cyc + 1, tv[i].exp_edges);
    chk($sformatf("v%0d_done", i), int'(done), 1);
    chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
    chk($sformatf("v%0d_pass", i), int'(pass_count), tv[i].exp_pass);
    chk($sformatf("v%0d_fail", i), int'(fail_count), tv[i].exp_fail);
    chk($sformatf("v%0d_first_fail", i), int'(first_fail), tv[i].exp_first);
    chk($sformatf("v%0d_failed", i), int'(failed), (tv[i].exp_fail != 0) ? 1 : 0);
    chk($sformatf("v%0d_image", i), int'(image_index), tv[i].exp_img);
    chk($sformatf("v%0d_label", i), int'(expected), tv[i].exp_label);
    chk($sformatf("v%0d_pix_count", i), pix_total, tv[i].exp_pix);
    chk($sformatf("v%0d_pix_data", i), pix_err, 0);
    chk($sformatf("v%0d_label_track", i), exp_err, 0);
  endtask

  initial begin
    int cyc;
    int bad;
    int addr_hold;

    rst = 1'b1; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0; pause = 1'b0;
    wrong_img = -1; wrong_val = 0;

    //        wrong val stop pass fail first img lab edges pix
    tv[0] = '{-1,  0,  0,   20,  0,   0,   19,  9,  760,  640};
    tv[1] = '{ 7,  8,  0,   19,  1,   7,   19,  9,  760,  640};
    tv[2] = '{ 7,  8,  1,    7,  1,   7,    7,  7,  304,  256};
    tv[3] = '{ 0,  5,  1,    0,  1,   0,    0,  0,   38,   32};
    tv[4] = '{19,  0,  0,   19,  1,  19,   19,  9,  760,  640};
    tv[5] = '{ 3, 12,  1,    3,  1,   3,    3,  3,  152,  128};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_pv", int'(pix_valid), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_failed", int'(failed), 0);
    chk("rst_pass", int'(pass_count), 0);
    chk("rst_fail", int'(fail_count), 0);
    chk("rst_image", int'(image_index), 0);
    chk("rst_label", int'(expected), 0);
    chk("rst_first_fail", int'(first_fail), 0);
    rst = 1'b0;

    // Asynchronous reset during FETCH of image 3
    pulse_start();
    cyc = 0;
    while (int'(rom_addr) != 3 * B + 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_img3", int'(rom_addr), 3 * B + 5);
    chk("mid_pass_before", int'(pass_count), 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_addr", int'(rom_addr), 0);
    chk("mid_rst_pv", int'(pix_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pass", int'(pass_count), 0);
    chk("mid_rst_image", int'(image_index), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rom_addr != '0 || busy || pix_valid) bad++;
    end
    chk("mid_rst_quiet", bad, 0);

    // Table of full runs; each after the first starts from DONE
    for (int i = 0; i < 6; i++) run_vec(i);

    // Pause held 10 cycles in NEXT after image 2
    wrong_img = -1; stop_on_fail = 1'b0;
    pulse_start();
    cyc = 0;
    bad = 0;
    addr_hold = 0;
    while (!done && cyc < 2000) begin
      if (cyc == 100) pause = 1'b1;
      if (cyc == 123) pause = 1'b0;
      if (cyc == 113) addr_hold = int'(rom_addr);
      if (cyc >= 113 && cyc <= 123)
        if (int'(rom_addr) != addr_hold || pix_valid || !busy) bad++;
      if (cyc == 124) begin
        chk("pause_first_addr", int'(rom_addr), 3 * B);
        chk("pause_image", int'(image_index), 3);
        chk("pause_label", int'(expected), 3);
      end
      @(negedge clk);
      cyc++;
    end
    chk("pause_hold_quiet", bad, 0);
    chk("pause_done_edges", cyc + 1, 770);
    chk("pause_pass", int'(pass_count), 20);
    chk("pause_fail", int'(fail_count), 0);
    chk("pause_pix_data", pix_err, 0);

    // Start mid-run ignored; abort at the 5th byte of image 4
    pulse_start();
    cyc = 0;
    while (cyc < 165) begin
      if (cyc == 50) start = 1'b1;
      if (cyc == 51) start = 1'b0;
      if (cyc == 60) begin
        chk("ign_start_image", int'(image_index), 1);
        chk("ign_start_addr", int'(rom_addr), B + 22);
      end
      if (cyc == 157) begin
        chk("abort_pv5", int'(pix_valid), 1);
        abort = 1'b1;
      end
      if (cyc == 158) begin
        abort = 1'b0;
        chk("abort_pv", int'(pix_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass_count), 4);
        chk("abort_fail", int'(fail_count), 0);
      end
      if (cyc == 164) begin
        chk("abort_idle_pv", int'(pix_valid), 0);
        chk("abort_idle_pass", int'(pass_count), 4);
      end
      @(negedge clk);
      cyc++;
    end

    // Restart from IDLE after abort clears the retained counters
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
